z80_spi_master: RTL and testbench

- Byte-wide SPI master for the SD card socket. It replaces software bit-banging of sd_mosi/sd_clk/sd_ssel_n through the GPIO output latch.
- Sits on the CPU IO bus beside the GPIO and VDP decoders, clocked by phi.
- Takes the top-level phi-synchronised IO read/write ticks. Shifts one byte full-duplex in SPI mode 0, MSB first, at a programmable SCLK rate.

---
 rtl/z80_spi_master_pkg.sv | 22 ++
 rtl/z80_spi_master_spi_shifter.sv | 104 ++++++++++
 rtl/z80_spi_master.sv | 127 ++++++++++++
 tb/tb_z80_spi_master.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/z80_spi_master_pkg.sv
// Shared definitions for the Z80 SD-card SPI master.
// Holds register offsets, status/control bit positions and the shifter state encoding.
package z80_spi_master_pkg;

    localparam logic [1:0] SPI_REG_DATA = 2'd0;
    localparam logic [1:0] SPI_REG_CTRL = 2'd1;
    localparam logic [1:0] SPI_REG_DIV  = 2'd2;

    localparam int SPI_ST_BUSY  = 7;
    localparam int SPI_ST_DONE  = 6;
    localparam int SPI_ST_OVR   = 5;
    localparam int SPI_CT_IRQEN = 1;
    localparam int SPI_CT_SSEL  = 0;

    // bit1 is SCLK and bit0 is busy, so both come straight off the state register
    typedef enum logic [1:0] {
        SPI_IDLE = 2'b00,
        SPI_LOW  = 2'b01,
        SPI_HIGH = 2'b11
    } spi_state_t;

endpackage

// File: rtl/z80_spi_master_spi_shifter.sv
// Mode-0 byte shifter: LOW/HIGH half-period FSM, divider counter and tx/rx shift registers.
// Divider is latched at transfer start so a mid-byte DIV change cannot alter the rate.
module spi_shifter
    import z80_spi_master_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 phi,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           tx_byte,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 miso,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 busy,
    output logic                 finish,
    output logic [7:0]           rx_byte
);

    spi_state_t           state_reg, state_next;
    logic [DIV_WIDTH-1:0] half_reg, half_next;
    logic [DIV_WIDTH-1:0] div_lat_reg, div_lat_next;
    logic [2:0]           bit_reg, bit_next;
    logic [7:0]           tx_reg, tx_next;
    logic [7:0]           rx_reg, rx_next;
    logic                 mosi_reg, mosi_next;

    always_ff @(posedge phi or posedge reset) begin
        if (reset) begin
            state_reg   <= SPI_IDLE;
            half_reg    <= '0;
            div_lat_reg <= '0;
            bit_reg     <= 3'd0;
            tx_reg      <= 8'h00;
            rx_reg      <= 8'h00;
            mosi_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            half_reg    <= half_next;
            div_lat_reg <= div_lat_next;
            bit_reg     <= bit_next;
            tx_reg      <= tx_next;
            rx_reg      <= rx_next;
            mosi_reg    <= mosi_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        half_next    = half_reg;
        div_lat_next = div_lat_reg;
        bit_next     = bit_reg;
        tx_next      = tx_reg;
        rx_next      = rx_reg;
        mosi_next    = mosi_reg;
        finish       = 1'b0;
        case (state_reg)
            SPI_IDLE: begin
                if (start) begin
                    state_next   = SPI_LOW;
                    half_next    = div;
                    div_lat_next = div;
                    bit_next     = 3'd7;
                    tx_next      = tx_byte;
                    mosi_next    = tx_byte[7];
                end
            end
            SPI_LOW: begin
                if (half_reg == '0) begin
                    state_next = SPI_HIGH;
                    half_next  = div_lat_reg;
                    rx_next    = {rx_reg[6:0], miso};
                end else begin
                    half_next = half_reg - DIV_WIDTH'(1);
                end
            end
            SPI_HIGH: begin
                if (half_reg == '0) begin
                    if (bit_reg == 3'd0) begin
                        state_next = SPI_IDLE;
                        mosi_next  = 1'b1;
                        finish     = 1'b1;
                    end else begin
                        state_next = SPI_LOW;
                        half_next  = div_lat_reg;
                        bit_next   = bit_reg - 3'd1;
                        tx_next    = {tx_reg[6:0], 1'b0};
                        mosi_next  = tx_reg[6];
                    end
                end else begin
                    half_next = half_reg - DIV_WIDTH'(1);
                end
            end
            default: state_next = SPI_IDLE;
        endcase
    end

    assign sclk    = state_reg[1];
    assign busy    = state_reg[0];
    assign mosi    = mosi_reg;
    assign rx_byte = rx_reg;

endmodule

// File: rtl/z80_spi_master.sv
// Z80 IO-mapped SPI master for the SD socket: register decode, sticky flags, optional irq.
// Define SPI_IRQ_EN to get the irq port and a writable irq_en bit in CTRL.
module z80_spi_master
    import z80_spi_master_pkg::*;
#(
    parameter int                   DIV_WIDTH = 8,
    parameter logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(31)
) (
    input  logic       phi,
    input  logic       reset,
    input  logic [1:0] cpu_addr,
    input  logic       cpu_wr_tick,
    input  logic       cpu_rd_tick,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       sd_clk,
    output logic       sd_mosi,
    input  logic       sd_miso,
    output logic       sd_ssel_n,
    output logic       busy
`ifdef SPI_IRQ_EN
    ,
    output logic       irq
`endif
);

    logic                 ssel_reg;
    logic                 done_reg;
    logic                 ovr_reg;
    logic [7:0]           rx_reg;
    logic [DIV_WIDTH-1:0] div_reg;
    logic                 irq_en;
    logic                 finish;
    logic [7:0]           shift_rx;
    logic                 start;
    logic                 reg_wr;
    logic                 status_rd;

    // Reserved offset 3 is not a real register, so writing it while busy is not an overrun.
    assign reg_wr    = cpu_wr_tick && (cpu_addr != 2'd3);
    assign start     = cpu_wr_tick && (cpu_addr == SPI_REG_DATA) && !busy;
    assign status_rd = cpu_rd_tick && !cpu_wr_tick && (cpu_addr == SPI_REG_CTRL);

    spi_shifter #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_shifter (
        .phi     (phi),
        .reset   (reset),
        .start   (start),
        .tx_byte (cpu_din),
        .div     (div_reg),
        .miso    (sd_miso),
        .sclk    (sd_clk),
        .mosi    (sd_mosi),
        .busy    (busy),
        .finish  (finish),
        .rx_byte (shift_rx)
    );

    always_ff @(posedge phi or posedge reset) begin
        if (reset) begin
            ssel_reg <= 1'b0;
            done_reg <= 1'b0;
            ovr_reg  <= 1'b0;
            rx_reg   <= 8'h00;
            div_reg  <= DIV_RESET;
        end else begin
            if (cpu_wr_tick && !busy) begin
                if (cpu_addr == SPI_REG_CTRL)
                    ssel_reg <= cpu_din[SPI_CT_SSEL];
                if (cpu_addr == SPI_REG_DIV)
                    div_reg <= DIV_WIDTH'(cpu_din);
            end
            if (finish)
                rx_reg <= shift_rx;
            // set beats clear on both sticky flags
            if (finish)
                done_reg <= 1'b1;
            else if (start || status_rd)
                done_reg <= 1'b0;
            if (reg_wr && busy)
                ovr_reg <= 1'b1;
            else if (status_rd)
                ovr_reg <= 1'b0;
        end
    end

`ifdef SPI_IRQ_EN
    logic irq_en_reg;
    logic irq_reg;

    always_ff @(posedge phi or posedge reset) begin
        if (reset) begin
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (cpu_wr_tick && !busy && (cpu_addr == SPI_REG_CTRL))
                irq_en_reg <= cpu_din[SPI_CT_IRQEN];
            irq_reg <= done_reg & irq_en_reg;
        end
    end

    assign irq_en = irq_en_reg;
    assign irq    = irq_reg;
`else
    assign irq_en = 1'b0;
`endif

    assign sd_ssel_n = ~ssel_reg;

    always_comb begin
        cpu_dout = 8'h00;
        case (cpu_addr)
            SPI_REG_DATA: cpu_dout = rx_reg;
            SPI_REG_CTRL: begin
                cpu_dout[SPI_ST_BUSY]  = busy;
                cpu_dout[SPI_ST_DONE]  = done_reg;
                cpu_dout[SPI_ST_OVR]   = ovr_reg;
                cpu_dout[SPI_CT_IRQEN] = irq_en;
                cpu_dout[SPI_CT_SSEL]  = ssel_reg;
            end
            SPI_REG_DIV:  cpu_dout = 8'(div_reg);
            default:      cpu_dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_z80_spi_master.sv
// Self-checking bench for z80_spi_master: scoreboard of expected tx/rx bytes and timing.
// Irq checks are compiled in only when SPI_IRQ_EN is defined.
module tb_z80_spi_master;

    logic       phi = 1'b0;
    logic       reset;
    logic [1:0] cpu_addr;
    logic       cpu_wr_tick;
    logic       cpu_rd_tick;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       sd_clk;
    logic       sd_mosi;
    logic       sd_miso;
    logic       sd_ssel_n;
    logic       busy;
`ifdef SPI_IRQ_EN
    logic       irq;
`endif

    always #5 phi = ~phi;

    z80_spi_master dut (
        .phi         (phi),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_wr_tick (cpu_wr_tick),
        .cpu_rd_tick (cpu_rd_tick),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .sd_clk      (sd_clk),
        .sd_mosi     (sd_mosi),
        .sd_miso     (sd_miso),
        .sd_ssel_n   (sd_ssel_n),
        .busy        (busy)
`ifdef SPI_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         div;
    } xfer_t;

    xfer_t      sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         div_model = 31;
    logic [7:0] slave_byte;
    logic       loop_mode;
    logic       irq_en_model = 1'b0;
    logic [7:0] rd;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge phi);
        cpu_addr    = a;
        cpu_din     = d;
        cpu_wr_tick = 1'b1;
        @(negedge phi);
        cpu_wr_tick = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge phi);
        cpu_addr    = a;
        cpu_rd_tick = 1'b1;
        #1 d = cpu_dout;
        @(negedge phi);
        cpu_rd_tick = 1'b0;
    endtask

    task automatic start_xfer(input logic [7:0] tx, input logic [7:0] slave, input logic lp);
        xfer_t e;
        slave_byte = slave;
        loop_mode  = lp;
        sd_miso    = lp ? tx[7] : slave[7];
        e.tx  = tx;
        e.rx  = lp ? tx : slave;
        e.div = div_model;
        sb.push_back(e);
        bus_write(2'd0, tx);
    endtask

    // Monitors one byte from the cycle after the DATA write until busy drops.
    task automatic run_xfer(input int inject);
        xfer_t      e;
        int         cyc = 0;
        int         rises = 0;
        int         highs = 0;
        int         budget;
        logic       prev = 1'b0;
        logic [7:0] cap = 8'h00;
        logic [7:0] got;
        e = sb.pop_front();
        budget = 16 * (e.div + 1) + 40;
        while (busy === 1'b1 && cyc < budget) begin
            if (sd_clk && !prev) begin
                cap = {cap[6:0], sd_mosi};
                rises++;
            end
            if (sd_clk) highs++;
            prev = sd_clk;
            if (loop_mode) sd_miso = sd_mosi;
            else if (rises < 8) sd_miso = slave_byte[7 - rises];
            if (inject >= 0 && cyc == inject) begin
                cpu_addr = 2'd0; cpu_din = 8'h00; cpu_wr_tick = 1'b1;
            end else if (inject >= 0 && cyc == inject + 1) begin
                cpu_addr = 2'd2; cpu_din = 8'h07;
            end else if (inject >= 0 && cyc == inject + 2) begin
                cpu_wr_tick = 1'b0;
            end
            @(negedge phi);
            cyc++;
        end
        cpu_wr_tick = 1'b0;
        check_val("busy_cycles", 32'(cyc), 32'(16 * (e.div + 1)));
        check_val("mosi_byte", {24'd0, cap}, {24'd0, e.tx});
        check_val("sclk_rises", 32'(rises), 32'd8);
        check_val("sclk_high_cycles", 32'(highs), 32'(8 * (e.div + 1)));
        check_val("idle_sclk", {31'd0, sd_clk}, 32'd0);
        check_val("idle_mosi", {31'd0, sd_mosi}, 32'd1);
`ifdef SPI_IRQ_EN
        check_val("irq_before_rise", {31'd0, irq}, 32'd0);
        @(negedge phi);
        check_val("irq_rise", {31'd0, irq}, {31'd0, irq_en_model});
`endif
        bus_read(2'd0, got);
        check_val("rx_data", {24'd0, got}, {24'd0, e.rx});
        $display("xfer tx=%02h rx=%02h div=%0d busy=%0d cycles", e.tx, got, e.div, cyc);
    endtask

    initial begin
        reset = 1'b1;
        cpu_addr = 2'd0; cpu_wr_tick = 1'b0; cpu_rd_tick = 1'b0;
        cpu_din = 8'h00; sd_miso = 1'b1;
        #1;
        check_val("rst_sclk", {31'd0, sd_clk}, 32'd0);
        check_val("rst_mosi", {31'd0, sd_mosi}, 32'd1);
        check_val("rst_ssel_n", {31'd0, sd_ssel_n}, 32'd1);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge phi);
        reset = 1'b0;
        bus_read(2'd0, rd); check_val("rst_data", {24'd0, rd}, 32'h00);
        bus_read(2'd1, rd); check_val("rst_status", {24'd0, rd}, 32'h00);
        bus_read(2'd2, rd); check_val("rst_div", {24'd0, rd}, 32'h1F);
        bus_read(2'd3, rd); check_val("rst_reserved", {24'd0, rd}, 32'h00);

        // div=0 loopback of A5
        bus_write(2'd2, 8'h00); div_model = 0;
        check_val("ssel_n_before", {31'd0, sd_ssel_n}, 32'd1);
        bus_write(2'd1, 8'h01);
        check_val("ssel_n_after", {31'd0, sd_ssel_n}, 32'd0);
        start_xfer(8'hA5, 8'h00, 1'b1);
        run_xfer(-1);
        bus_read(2'd1, rd); check_val("status_a5", {24'd0, rd}, 32'h41);

        // div=3, slave returns 3C
        bus_write(2'd2, 8'h03); div_model = 3;
        start_xfer(8'h96, 8'h3C, 1'b0);
        run_xfer(-1);
        bus_read(2'd1, rd); check_val("status_3c", {24'd0, rd}, 32'h41);

        // writes during a byte are ignored and flag an overrun
        bus_write(2'd1, 8'h00);
        start_xfer(8'hFF, 8'h5A, 1'b0);
        run_xfer(10);
        bus_read(2'd1, rd); check_val("status_ovr", {24'd0, rd}, 32'h60);
        bus_read(2'd1, rd); check_val("status_reread", {24'd0, rd}, 32'h00);
        bus_read(2'd2, rd); check_val("div_kept", {24'd0, rd}, 32'h03);

        // reserved register ignores writes
        bus_write(2'd3, 8'hAB);
        bus_read(2'd3, rd); check_val("reserved_wr", {24'd0, rd}, 32'h00);
        bus_read(2'd2, rd); check_val("div_after_rsv", {24'd0, rd}, 32'h03);

`ifdef SPI_IRQ_EN
        bus_write(2'd2, 8'h00); div_model = 0;
        bus_write(2'd1, 8'h03); irq_en_model = 1'b1;
        start_xfer(8'h12, 8'h00, 1'b1);
        run_xfer(-1);
        bus_read(2'd1, rd); check_val("status_irq", {24'd0, rd}, 32'h43);
        check_val("irq_hold", {31'd0, irq}, 32'd1);
        @(negedge phi);
        check_val("irq_clear", {31'd0, irq}, 32'd0);
        bus_write(2'd1, 8'h01); irq_en_model = 1'b0;
        start_xfer(8'h34, 8'h00, 1'b1);
        run_xfer(-1);
        check_val("irq_disabled", {31'd0, irq}, 32'd0);
        bus_read(2'd1, rd); check_val("status_noirq", {24'd0, rd}, 32'h41);
`endif

        // reset in the middle of bit 3 while SCLK is high
        bus_write(2'd2, 8'h01); div_model = 1;
        bus_write(2'd1, 8'h01);
        start_xfer(8'h81, 8'hC3, 1'b0);
        repeat (18) @(negedge phi);
        check_val("pre_reset_sclk", {31'd0, sd_clk}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_sclk", {31'd0, sd_clk}, 32'd0);
        check_val("mid_rst_ssel_n", {31'd0, sd_ssel_n}, 32'd1);
        check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_val("mid_rst_mosi", {31'd0, sd_mosi}, 32'd1);
        sb.delete();
        irq_en_model = 1'b0;
        @(negedge phi);
        reset = 1'b0;
        div_model = 31;
        bus_read(2'd0, rd); check_val("post_rst_data", {24'd0, rd}, 32'h00);
        bus_read(2'd1, rd); check_val("post_rst_status", {24'd0, rd}, 32'h00);
        bus_read(2'd2, rd); check_val("post_rst_div", {24'd0, rd}, 32'h1F);
        bus_write(2'd2, 8'h02); div_model = 2;
        start_xfer(8'h3C, 8'hE7, 1'b0);
        run_xfer(-1);
        bus_read(2'd1, rd); check_val("post_rst_done", {24'd0, rd}, 32'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
